// File: rtl/amiga_daug_pkg.sv
// Shared types and constants for the A1000 daughterboard DRAM controller.
// Holds the FSM state encoding, _CAS bit positions and the row/column address split.
package amiga_daug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ROW  = 3'd1,
        ST_COL  = 3'd2,
        ST_HOLD = 3'd3,
        ST_PRE  = 3'd4,
        ST_RCAS = 3'd5,
        ST_RRAS = 3'd6
    } state_t;

    localparam int CAS_B0_LO = 0;
    localparam int CAS_B0_HI = 1;
    localparam int CAS_B1_LO = 2;
    localparam int CAS_B1_HI = 3;

    localparam int ROW_LSB = 1;
    localparam int ROW_MSB = 8;
    localparam int COL_LSB = 9;
    localparam int COL_MSB = 16;

    // Only the addressed bank sees the data strobes; the other bank stays deselected.
    function automatic logic [3:0] cas_pattern(input logic bank, input logic uds_n,
                                               input logic lds_n);
        logic [3:0] p;
        p = 4'hF;
        if (bank) begin
            p[CAS_B1_HI] = uds_n;
            p[CAS_B1_LO] = lds_n;
        end else begin
            p[CAS_B0_HI] = uds_n;
            p[CAS_B0_LO] = lds_n;
        end
        return p;
    endfunction

endpackage

// File: rtl/amiga_daug_refresh_timer.sv
// Free-running refresh interval counter with a sticky request flag.
// The request is also raised during the wrap clock itself so a same-edge bus request loses.
module amiga_daug_refresh_timer #(
    parameter int REF_DIV = 110
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_req
);

    localparam int CW = $clog2(REF_DIV);

    logic [CW-1:0] r_cnt;
    logic          r_pending;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(REF_DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else begin
            r_cnt     <= w_wrap ? '0 : r_cnt + 1'b1;
            r_pending <= w_wrap | (r_pending & ~i_clr);
        end
    end

    assign o_req = r_pending | w_wrap;

endmodule

// File: rtl/amiga_daug_dram_ctrl.sv
// DRAM timing controller for the A1000 daughterboard WOM: row/col mux, _RAS/_CAS,
// early write, buffer enables, _DTACK, CBR refresh and the write-protect latch.
module amiga_daug_dram_ctrl
    import amiga_daug_pkg::*;
#(
    parameter int T_RCD   = 2,
    parameter int T_RP    = 2,
    parameter int T_REF   = 2,
    parameter int REF_DIV = 110
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_sel,
    input  logic        i_as_n,
    input  logic        i_uds_n,
    input  logic        i_lds_n,
    input  logic        i_prw,
    input  logic [17:1] i_a,
    input  logic        i_wp_set,
    output logic [7:0]  o_ma,
    output logic        o_ras_n,
    output logic [3:0]  o_cas_n,
    output logic        o_we_n,
    output logic        o_cdr_n,
    output logic        o_cdw_n,
    output logic        o_dtack_n,
    output logic        o_wpro,
    output logic [2:0]  o_dbg_state
);

    state_t      r_state, w_state;
    logic [2:0]  r_cnt, w_cnt;
    logic [7:0]  r_ma, w_ma;
    logic        r_ras_n, w_ras_n;
    logic [3:0]  r_cas_n, w_cas_n;
    logic        r_we_n, w_we_n;
    logic        r_cdr_n, w_cdr_n;
    logic        r_cdw_n, w_cdw_n;
    logic        r_dtack_n, w_dtack_n;
    logic        r_read, w_read;
    logic        r_wr_blk, w_wr_blk;
    logic        r_wpro;
    logic        w_req, w_ref_req, w_ref_clr;

    amiga_daug_refresh_timer #(.REF_DIV(REF_DIV)) u_refresh (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_ref_clr),
        .o_req   (w_ref_req)
    );

    assign w_req = i_sel & ~i_as_n & (~i_uds_n | ~i_lds_n);

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_ma      = r_ma;
        w_ras_n   = r_ras_n;
        w_cas_n   = r_cas_n;
        w_we_n    = r_we_n;
        w_cdr_n   = r_cdr_n;
        w_cdw_n   = r_cdw_n;
        w_dtack_n = r_dtack_n;
        w_read    = r_read;
        w_wr_blk  = r_wr_blk;
        w_ref_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ref_req) begin
                    w_state = ST_RCAS;
                    w_cas_n = 4'h0;
                end else if (w_req) begin
                    w_state  = ST_ROW;
                    w_cnt    = '0;
                    w_ma     = i_a[ROW_MSB:ROW_LSB];
                    w_ras_n  = 1'b0;
                    w_read   = i_prw;
                    // Protection is frozen for the whole cycle at request time.
                    w_wr_blk = ~i_prw & r_wpro;
                    if (!i_prw) begin
                        w_cdw_n = 1'b0;
                        w_we_n  = r_wpro;
                    end
                end
            end
            ST_ROW: begin
                if (i_as_n) begin
                    w_state = ST_PRE;
                    w_cnt   = '0;
                    w_ras_n = 1'b1;
                    w_we_n  = 1'b1;
                    w_cdw_n = 1'b1;
                end else if (r_cnt == 3'(T_RCD - 1)) begin
                    w_state   = ST_COL;
                    w_ma      = i_a[COL_MSB:COL_LSB];
                    w_dtack_n = 1'b0;
                    w_cdr_n   = ~r_read;
                    if (!r_wr_blk) begin
                        w_cas_n = cas_pattern(i_a[17], i_uds_n, i_lds_n);
                    end
                end else begin
                    w_cnt = r_cnt + 3'd1;
                end
            end
            ST_COL: begin
                w_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (i_as_n) begin
                    w_state   = ST_PRE;
                    w_cnt     = '0;
                    w_ras_n   = 1'b1;
                    w_cas_n   = 4'hF;
                    w_we_n    = 1'b1;
                    w_cdr_n   = 1'b1;
                    w_cdw_n   = 1'b1;
                    w_dtack_n = 1'b1;
                end else begin
                    w_cdr_n = ~r_read;
                end
            end
            ST_PRE: begin
                if (r_cnt == 3'(T_RP - 1)) begin
                    w_state = ST_IDLE;
                end else begin
                    w_cnt = r_cnt + 3'd1;
                end
            end
            ST_RCAS: begin
                w_state = ST_RRAS;
                w_cnt   = '0;
                w_ras_n = 1'b0;
            end
            ST_RRAS: begin
                if (r_cnt == 3'(T_REF - 1)) begin
                    w_state   = ST_PRE;
                    w_cnt     = '0;
                    w_ras_n   = 1'b1;
                    w_cas_n   = 4'hF;
                    w_ref_clr = 1'b1;
                end else begin
                    w_cnt = r_cnt + 3'd1;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_ma      <= '0;
            r_ras_n   <= 1'b1;
            r_cas_n   <= 4'hF;
            r_we_n    <= 1'b1;
            r_cdr_n   <= 1'b1;
            r_cdw_n   <= 1'b1;
            r_dtack_n <= 1'b1;
            r_read    <= 1'b1;
            r_wr_blk  <= 1'b0;
            r_wpro    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_ma      <= w_ma;
            r_ras_n   <= w_ras_n;
            r_cas_n   <= w_cas_n;
            r_we_n    <= w_we_n;
            r_cdr_n   <= w_cdr_n;
            r_cdw_n   <= w_cdw_n;
            r_dtack_n <= w_dtack_n;
            r_read    <= w_read;
            r_wr_blk  <= w_wr_blk;
            r_wpro    <= r_wpro | i_wp_set;
        end
    end

    assign o_ma        = r_ma;
    assign o_ras_n     = r_ras_n;
    assign o_cas_n     = r_cas_n;
    assign o_we_n      = r_we_n;
    assign o_cdr_n     = r_cdr_n;
    assign o_cdw_n     = r_cdw_n;
    assign o_dtack_n   = r_dtack_n;
    assign o_wpro      = r_wpro;
    assign o_dbg_state = r_state;

endmodule

// File: doc/amiga_daug_dram_ctrl.md
Name: amiga_daug_dram_ctrl

Overview:
Synchronous DRAM timing controller for the A1000 daughterboard 256 KB WOM array (8 x 41464, two 64Kx16 banks).
- Sits directly upstream of the RAM array and the data latch/buffer stage. It consumes the decoded 68000 bus cycle and produces the multiplexed row/column address, _RAS, four _CAS lines, _WE, buffer enables and _DTACK.
- Also issues CAS-before-RAS refresh and owns the write-protect (WPRO) latch.

Parameters:
- T_RCD, 2: clocks _RAS is low with row address before column/_CAS phase (1..7).
- T_RP, 2: precharge clocks after _RAS rises before next cycle (1..7).
- T_REF, 2: clocks _RAS is held low during a refresh (1..7).
- REF_DIV, 110: clocks between refresh requests (15.5 us at 7.09 MHz). Minimum 16.

Ports:
- CLK, in, 1: system clock, rising edge.
- _RST, in, 1: asynchronous active-low reset.
- SEL, in, 1: board address decode hit, active high.
- _AS, in, 1: 68000 address strobe.
- _UDS, in, 1: upper data strobe.
- _LDS, in, 1: lower data strobe.
- _PRW, in, 1: 1 = read, 0 = write.
- A, in, 17 ([17:1]): word address. A[17] selects the bank.
- WP_SET, in, 1: one-clock pulse that engages write protect.
- MA, out, 8: DRAM multiplexed address.
- _RAS, out, 1: row strobe, common to all devices.
- _CAS, out, 4: {bank1 upper, bank1 lower, bank0 upper, bank0 lower}.
- _WE, out, 1: DRAM write enable.
- _CDR, out, 1: read latch output enable to CPU bus.
- _CDW, out, 1: write buffer enable to DRAM data bus.
- _DTACK, out, 1: data acknowledge, driven low only when acknowledging.
- WPRO, out, 1: write-protect status, also drives the LED.

Behaviour:
- Reset values: _RAS=1, _CAS=4'hF, _WE=1, _CDR=1, _CDW=1, _DTACK=1, MA=0, WPRO=0, refresh counter=0, pending=0, state IDLE. Reset mid-cycle aborts immediately.
- Address split: row = A[8:1], col = A[16:9].
- Request: in IDLE, SEL & !_AS & (!_UDS | !_LDS) sampled high.
- States: IDLE, ROW, COL, HOLD, PRE, RCAS, RRAS.
- IDLE, refresh pending: go to RCAS. Refresh wins over a request sampled at the same edge; the request is served after the following PRE.
- IDLE, request (no pending refresh): go to ROW.
  - MA<=row, _RAS<=0.
  - For a write: _CDW<=0, and _WE<=0 only if WPRO=0 (early write).
- ROW: count T_RCD clocks, then go to COL.
  - If _AS is seen high during ROW (aborted cycle), go to PRE with _RAS<=1, _WE<=1, _CDW<=1. No _CAS, no _DTACK.
- COL, one clock:
  - MA<=col and _DTACK<=0.
  - Drive _CAS[{A17,1}] <= _UDS and _CAS[{A17,0}] <= _LDS; the other bank stays 1.
  - Write with WPRO=1: all _CAS stay 1 and data is dropped, but _DTACK is still asserted.
  - Then go to HOLD.
- HOLD: on a read, _CDR=0 while _AS is low. Stay until _AS is sampled high, then:
  - _RAS, _CAS, _WE, _CDR, _CDW, _DTACK <= 1.
  - Go to PRE.
- PRE: count T_RP clocks with _RAS high, then go to IDLE.
- RCAS: _CAS<=4'h0 (CBR setup), then go to RRAS.
- RRAS: _RAS<=0 for T_REF clocks, then _RAS<=1, _CAS<=4'hF, clear pending, go to PRE.
- Refresh timer:
  - Free-running modulo-REF_DIV counter. Sets pending on wrap to 0.
  - A wrap while pending is already set keeps pending=1 (no queueing).
  - The counter never stalls.
- Write protect:
  - WP_SET sets WPRO on the next edge; only _RST clears it.
  - A WP_SET during an active write takes effect on the next cycle; the current _WE is unchanged.
- Throughput:
  - Latency from request edge to _DTACK low is T_RCD+1 clocks.
  - Back-to-back cycles are separated by at least T_RP clocks.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package amiga_daug_pkg: state enum, a CAS index constant per bank/byte, and the row/col bit-range constants.
- Sub-module amiga_daug_refresh_timer: counter plus pending flag, with a clear input from the FSM.

Test Plan:
- Reset check: assert _RST mid-ROW -> all outputs at reset values asynchronously; WPRO=0.
- Upper-byte read, bank 1: A=17'h12345, _UDS=0, _LDS=1, _PRW=1.
  - MA=8'h45 with _RAS low for 2 clocks, then MA=8'h23.
  - _CAS=4'b0111, _DTACK low at clock 3, _CDR low until _AS rises.
- Word write, bank 0: A=17'h00A0F, both DS low, _PRW=0.
  - _WE and _CDW low from the ROW edge, _CAS=4'b1100.
  - All strobes high the clock after _AS rises, then 2 precharge clocks.
- Protected write: pulse WP_SET, then write.
  - _CAS stays 4'hF and _WE stays 1.
  - _DTACK is still asserted; WPRO=1.
- Refresh/request collision: request and counter wrap at the same edge.
  - _CAS=4'h0 one clock before _RAS low for 2 clocks.
  - Then 2 PRE clocks, then the request is served.
- Aborted cycle: raise _AS during ROW -> no _CAS, no _DTACK, 2 PRE clocks, return to IDLE.
